// File: rtl/arvi_bus_pkg.sv
// rtl/arvi_bus_pkg.sv - shared bus widths and slave state encoding
package arvi_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_RECOVER
  } bus_state_e;
endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - request/response bus between a master and a memory slave
interface bus_if;
  import arvi_bus_pkg::*;

  logic              bus_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   byte_en;
  logic [DATA_W-1:0] rd_data;
  logic              ack;

  modport master (output bus_en, wr_en, addr, wr_data, byte_en, input rd_data, ack);
  modport slave  (input bus_en, wr_en, addr, wr_data, byte_en, output rd_data, ack);
endinterface

// File: rtl/bus_mem_array.sv
// rtl/bus_mem_array.sv - single-port word storage, synchronous read, byte-lane write
module bus_mem_array
  import arvi_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              i_clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BE_W-1:0]   byte_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (byte_en[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end else begin
        rd_data <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/bus_mem_slave.sv
// rtl/bus_mem_slave.sv - wait-stated memory slave with range fault and one-cycle ack
module bus_mem_slave
  import arvi_bus_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter int              WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic i_clk,
  input  logic i_rst,
  bus_if.slave bus_s,
  output logic o_fault
);
  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e        state_q, state_d;
  logic [3:0]        cnt_q;
  logic              wr_q, in_range_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [ADDR_W-1:0] offset;
  logic              in_range, take, rd_en, mem_we, mem_en;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign offset   = bus_s.addr - BASE_ADDR;
  assign in_range = (bus_s.addr >= BASE_ADDR) && ((offset >> 2) < ADDR_W'(DEPTH_WORDS));
  assign take     = (state_q == ST_IDLE) && bus_s.bus_en;

  // Read is launched on the edge entering RESP; with no wait states that edge
  // is the sampling edge itself, so the live bus fields address the array.
  assign rd_en = (state_d == ST_RESP) &&
                 ((state_q == ST_IDLE) ? (!bus_s.wr_en && in_range) : (!wr_q && in_range_q));
  assign mem_we  = (state_q == ST_RESP) && wr_q && in_range_q;
  assign mem_en  = rd_en || mem_we;
  assign mem_idx = (state_q == ST_IDLE) ? offset[IDX_W+1:2] : idx_q;

  bus_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .i_clk   (i_clk),
    .en      (mem_en),
    .we      (mem_we),
    .idx     (mem_idx),
    .byte_en (be_q),
    .wr_data (wdata_q),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus_s.ack     = 1'b0;
    bus_s.rd_data = '0;
    o_fault       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_s.bus_en) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d   = ST_RECOVER;
        bus_s.ack = 1'b1;
        o_fault   = !in_range_q;
        if (!wr_q && in_range_q) bus_s.rd_data = mem_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else if (take) begin
      cnt_q      <= WAIT_LOAD;
      wr_q       <= bus_s.wr_en;
      in_range_q <= in_range;
      idx_q      <= offset[IDX_W+1:2];
      wdata_q    <= bus_s.wr_data;
      be_q       <= bus_s.byte_en;
    end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb/tb_bus_mem_slave.sv - scoreboard bench for bus_mem_slave with two wait-state settings
module tb_bus_mem_slave;
  import arvi_bus_pkg::*;

  localparam int          DEPTH  = 1024;
  localparam int          W_A    = 2;
  localparam logic [31:0] BASE_Z = 32'h0000_2000;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic fault_a, fault_z;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  bus_if bus_a();
  bus_if bus_z();

  bus_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A), .BASE_ADDR(32'h0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus_s(bus_a), .o_fault(fault_a));

  bus_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE_Z)) dut_z (
    .i_clk(i_clk), .i_rst(i_rst), .bus_s(bus_z), .o_fault(fault_z));

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          ack_cyc;
    logic [31:0] rd;
    logic        fault;
    string       name;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_z[$];
  logic [31:0] mdl [2][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic mon(input int sel, input logic ack, input logic [31:0] rd, input logic fault);
    exp_t e;
    int   qn;
    if (ack !== 1'b1) begin
      check("ack_low", {31'b0, ack}, 32'h0);
      check("rd_data_idle", rd, 32'h0);
      check("fault_idle", {31'b0, fault}, 32'h0);
    end else begin
      qn = (sel == 0) ? q_a.size() : q_z.size();
      checks++;
      if (qn == 0) begin
        failures++;
        $display("FAIL unexpected_ack port=%0d actual=ack required=no_ack cyc=%0d", sel, cyc);
      end else begin
        if (sel == 0) e = q_a.pop_front();
        else          e = q_z.pop_front();
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.ack_cyc));
        check({e.name, "_rd"}, rd, e.rd);
        check({e.name, "_fault"}, {31'b0, fault}, {31'b0, e.fault});
      end
    end
  endtask

  always @(negedge i_clk) begin
    mon(0, bus_a.ack, bus_a.rd_data, fault_a);
    mon(1, bus_z.ack, bus_z.rd_data, fault_z);
  end

  task automatic set_bus(input int sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (sel == 0) begin
      bus_a.bus_en = en; bus_a.wr_en = wr; bus_a.addr = a; bus_a.wr_data = d; bus_a.byte_en = be;
    end else begin
      bus_z.bus_en = en; bus_z.wr_en = wr; bus_z.addr = a; bus_z.wr_data = d; bus_z.byte_en = be;
    end
  endtask

  task automatic garbage(input int sel, input bit hold);
    set_bus(sel, hold ? 1'b1 : 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
  endtask

  // Reference: a word is addressable iff at/above the base and its word index fits.
  task automatic model_access(input int sel, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] be,
                              output logic [31:0] rd, output logic fault);
    logic [31:0] base, off;
    int          idx;
    base  = (sel == 0) ? 32'h0 : BASE_Z;
    off   = addr - base;
    fault = !((addr >= base) && ((off / 4) < DEPTH));
    rd    = 32'h0;
    if (!fault) begin
      idx = int'(off / 4);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[sel][idx][8*i +: 8] = data[8*i +: 8];
      end else begin
        rd = mdl[sel][idx];
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic issue(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be,
                       input string name, input bit hold);
    exp_t e;
    logic got;
    e.ack_cyc = cyc + 1 + ((sel == 0) ? W_A : 0);
    e.name    = name;
    model_access(sel, wr, addr, data, be, e.rd, e.fault);
    if (sel == 0) q_a.push_back(e);
    else          q_z.push_back(e);
    set_bus(sel, 1'b1, wr, addr, data, be);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge i_clk);
      got = (sel == 0) ? bus_a.ack : bus_z.ack;
      garbage(sel, hold);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ack required=ack", name);
    end
    @(negedge i_clk);
    garbage(sel, hold);
    @(negedge i_clk);
    set_bus(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ack"}, {31'b0, bus_a.ack}, 32'h0);
    check({name, "_rd"}, bus_a.rd_data, 32'h0);
    check({name, "_fault"}, {31'b0, fault_a}, 32'h0);
  endtask

  task automatic reset_tests();
    exp_t e;
    logic got;
    // Read of 0x30 aborted asynchronously while its ack is showing.
    e.ack_cyc = cyc + 1 + W_A;
    e.name    = "rst_resp_read";
    model_access(0, 1'b0, 32'h30, 32'h0, 4'h0, e.rd, e.fault);
    q_a.push_back(e);
    set_bus(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge i_clk);
      got = bus_a.ack;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL rst_resp_timeout actual=no_ack required=ack");
    end
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 i_rst = 1'b1;
    #1 check_outputs_zero("rst_in_resp");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    // Write to 0x30 aborted in WAIT must leave the old word intact.
    set_bus(0, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
    @(negedge i_clk);
    set_bus(0, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
    #2 i_rst = 1'b1;
    #1 check_outputs_zero("rst_in_wait");
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge i_clk);
    check_outputs_zero("rst_held");
    i_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge i_clk);
    check_outputs_zero("reset");
    i_rst = 1'b0;

    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "w10", 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, "r10", 1'b0);
    issue(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, "w20", 1'b0);
    issue(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, "w20_be", 1'b0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, "r20", 1'b0);
    issue(0, 1'b1, 32'h0FFC, 32'h5A5A_1234, 4'hF, "wffc", 1'b0);
    issue(0, 1'b0, 32'h1000, 32'h0, 4'h0, "r1000_fault", 1'b0);
    issue(0, 1'b0, 32'h0FFC, 32'h0, 4'h0, "rffc", 1'b0);
    issue(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, "w1000_fault", 1'b0);
    issue(0, 1'b1, 32'h42, 32'h0BAD_F00D, 4'hF, "w42", 1'b0);
    issue(0, 1'b0, 32'h40, 32'h0, 4'h0, "r40", 1'b0);
    issue(0, 1'b1, 32'h40, 32'h1357_9BDF, 4'h0, "w40_be0", 1'b0);
    issue(0, 1'b0, 32'h43, 32'h0, 4'h0, "r43", 1'b0);
    issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, "rtop_fault", 1'b0);
    issue(0, 1'b1, 32'h30, 32'h1234_5678, 4'hF, "w30", 1'b0);
    reset_tests();
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0, "r30_kept", 1'b0);

    for (int w = 0; w < 16; w++)
      issue(0, 1'b1, 32'(w * 4), $urandom, 4'hF, "init_a", 1'b0);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (r < 9) a = 32'h1000 + 32'($urandom_range(0, 4095));
      else            a = $urandom | 32'h8000_0000;
      issue(0, 1'($urandom), a, $urandom, 4'($urandom), "rand_a", 1'($urandom_range(0, 3) == 0));
    end

    for (int w = 0; w < 16; w++)
      issue(1, 1'b1, BASE_Z + 32'(w * 4), $urandom, 4'hF, "init_z", 1'b0);
    issue(1, 1'b0, BASE_Z, 32'h0, 4'h0, "z_hold_read", 1'b1);
    issue(1, 1'b0, BASE_Z - 32'h4, 32'h0, 4'h0, "z_below_base", 1'b0);
    issue(1, 1'b0, BASE_Z + 32'h1000, 32'h0, 4'h0, "z_above_top", 1'b0);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = BASE_Z + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (r < 9) a = 32'($urandom_range(0, 32'h1FFF));
      else            a = BASE_Z + 32'h1000 + 32'($urandom_range(0, 255));
      issue(1, 1'($urandom), a, $urandom, 4'($urandom), "rand_z", 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge i_clk);
    checks++;
    if (q_a.size() != 0 || q_z.size() != 0) begin
      failures++;
      $display("FAIL pending_acks actual=%0d required=0", q_a.size() + q_z.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bus_mem_slave.md
BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the extra wait states before ack (0..15).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-high.
REQ-006 bus_s  bus_if.slave  --  carries bus_en(1), wr_en(1), addr(32), wr_data(32), byte_en(4) from the master, and rd_data(32), ack(1) to the master; atomic/operation fields are ignored.
REQ-007 o_fault  output  1  single-cycle pulse, coincident with ack, marking an out-of-range access.

Function
REQ-008 The block SHALL implement a state machine with states IDLE, WAIT, RESP and RECOVER.
REQ-009 In IDLE with bus_en=1, the block SHALL capture addr, wr_en, wr_data and byte_en in one cycle.
  - With WAIT_CYCLES>0 it SHALL go to WAIT and load the wait counter with WAIT_CYCLES-1.
  - With WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-010 In WAIT the counter SHALL decrement once per cycle; at zero the block SHALL go to RESP.
REQ-011 ack SHALL be 1 only in RESP, for exactly one cycle; RESP SHALL always go to RECOVER.
REQ-012 Latency: request first sampled in IDLE at cycle T -> ack at cycle T+1+WAIT_CYCLES.
REQ-013 RECOVER SHALL last one cycle, ignore bus_en, then go to IDLE, so a held bus_en is never acked twice.
REQ-014 Word index SHALL be (addr-BASE_ADDR)>>2; addr[1:0] SHALL be ignored.
  - An access is in range iff addr>=BASE_ADDR and index<DEPTH_WORDS.
REQ-015 Write, in range: bytes with byte_en[i]=1 SHALL be updated from wr_data[8i+7:8i] at the RESP rising edge; other bytes SHALL be unchanged.
REQ-016 Read, in range: rd_data SHALL present the addressed word during the RESP cycle.
REQ-017 Out-of-range access: storage SHALL NOT change, rd_data SHALL be 0, and o_fault=1 with ack.
REQ-018 Request inputs SHALL be sampled only in IDLE; changes during WAIT/RESP/RECOVER SHALL have no effect.
REQ-019 rd_data SHALL be 0 outside RESP, and 0 in RESP for writes.
REQ-020 A write with byte_en=4'b0000 SHALL be acked normally and change nothing.

Reset
REQ-021 While i_rst=1, state SHALL be IDLE, the counter 0, and ack, o_fault and rd_data 0, regardless of clock.
REQ-022 Reset mid-operation SHALL abandon the transaction without ack or write; storage contents SHALL NOT be cleared.
REQ-023 The first request SHALL be sampled on the first rising edge after i_rst deasserts.

Structure
REQ-024 The state enum and bus width constants (ADDR 32, DATA 32, BE 4) SHALL live in shared package arvi_bus_pkg.
REQ-025 Storage SHALL be a sub-module, bus_mem_array: single port, synchronous read, 4-lane byte-enable write, no reset.
REQ-026 Expected size is about 150-250 RTL lines.

Verification
REQ-027 Defaults: write 0xDEADBEEF, byte_en 1111, to 0x10 -> ack at T+3; then read 0x10 -> rd_data 0xDEADBEEF with ack at T+3.
REQ-028 Write 0x11223344, byte_en 0101, over 0xAABBCCDD at 0x20 -> read returns 0xAA22CC44.
REQ-029 WAIT_CYCLES=0: read 0x0 -> ack at T+1; bus_en held high through the ack -> no second ack in the RECOVER cycle.
REQ-030 Read of 0x1000 (index 1024) -> ack with rd_data 0 and o_fault=1; a following read of 0x0FFC -> o_fault 0.
REQ-031 i_rst asserted mid-clock while in WAIT of a write to 0x30 -> outputs 0 immediately, no ack, and 0x30 retains its old value.
REQ-032 Write to 0x42 -> word 0x40 updated, addr[1:0] ignored.
